// File: rtl/bg_subtract_detector.sv
// Per-pixel background-model foreground detector over a raster stream with ready/valid output.
// Define ADAPTIVE_BG_EN to let background pixels keep updating the model as a running average.
module bg_subtract_detector #(
    parameter int unsigned NUM_ROWS   = 10,
    parameter int unsigned NUM_COLS   = 10,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned TRAIN_LOG2 = 2,
    localparam int unsigned CNT_W     = $clog2(NUM_ROWS * NUM_COLS + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_mode,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_thresh,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_fg,
    output logic              o_last,
    output logic [CNT_W-1:0]  o_fg_count,
    output logic              o_done_training
);

    localparam int unsigned N            = NUM_ROWS * NUM_COLS;
    localparam int unsigned IDX_W        = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned ACC_W        = DATA_W + TRAIN_LOG2;
    localparam int unsigned TCNT_W       = TRAIN_LOG2 + 1;
    localparam int unsigned TRAIN_FRAMES = 1 << TRAIN_LOG2;

    typedef enum logic [1:0] {StTrain, StTrained, StDetect} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [TCNT_W-1:0]  tcnt_q;
    logic               mode_q;
    logic [CNT_W-1:0]   fg_acc_q;
    logic [ACC_W-1:0]   acc [N];

    logic               accept, frame_start, frame_end, cur_mode;
    logic               train_wr, detect_px, fg;
    logic [ACC_W-1:0]   acc_rd;
    logic [DATA_W-1:0]  bg;
    logic [DATA_W:0]    diff;
    logic [CNT_W-1:0]   fg_acc_next;

    assign o_in_ready  = !o_valid || i_ready;
    assign accept      = i_valid && o_in_ready;
    assign frame_start = (idx_q == '0);
    assign frame_end   = (idx_q == IDX_W'(N - 1));
    // Mode is only taken from the port on the first pixel of a frame.
    assign cur_mode    = frame_start ? i_mode : mode_q;

    assign acc_rd = acc[idx_q];
    assign bg     = DATA_W'(acc_rd >> TRAIN_LOG2);
    assign diff   = (i_data >= bg) ? ({1'b0, i_data} - {1'b0, bg})
                                   : ({1'b0, bg} - {1'b0, i_data});
    assign fg     = (diff > {1'b0, i_thresh});

    assign fg_acc_next     = (frame_start ? '0 : fg_acc_q) + CNT_W'(fg);
    assign o_done_training = (state_q != StTrain);

    always_comb begin
        state_d   = state_q;
        train_wr  = 1'b0;
        detect_px = 1'b0;
        case (state_q)
            StTrain: begin
                if (accept && !cur_mode) begin
                    train_wr = 1'b1;
                    if (frame_end && tcnt_q == TCNT_W'(TRAIN_FRAMES - 1)) begin
                        state_d = StTrained;
                    end
                end
            end
            StTrained: begin
                if (accept && cur_mode) begin
                    detect_px = 1'b1;
                    state_d   = StDetect;
                end
            end
            StDetect: begin
                if (accept && cur_mode) begin
                    detect_px = 1'b1;
                end
            end
            default: state_d = StTrain;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= StTrain;
            idx_q      <= '0;
            tcnt_q     <= '0;
            mode_q     <= 1'b0;
            fg_acc_q   <= '0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_fg       <= 1'b0;
            o_last     <= 1'b0;
            o_fg_count <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q <= frame_end ? '0 : idx_q + IDX_W'(1);
                if (frame_start) begin
                    mode_q <= i_mode;
                end
            end
            if (train_wr && frame_end) begin
                tcnt_q <= tcnt_q + TCNT_W'(1);
            end
            if (detect_px) begin
                o_valid  <= 1'b1;
                o_data   <= i_data;
                o_fg     <= fg;
                o_last   <= frame_end;
                fg_acc_q <= fg_acc_next;
                if (frame_end) begin
                    o_fg_count <= fg_acc_next;
                end
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

    // Model storage is deliberately not reset; training frame 0 overwrites it.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (train_wr) begin
                acc[idx_q] <= (tcnt_q == '0) ? ACC_W'(i_data) : acc_rd + ACC_W'(i_data);
            end
`ifdef ADAPTIVE_BG_EN
            else if (detect_px && !fg) begin
                acc[idx_q] <= acc_rd - (acc_rd >> TRAIN_LOG2) + ACC_W'(i_data);
            end
`else
            else begin
            end
`endif
        end
    end

endmodule

// File: tb/tb_bg_subtract_detector.sv
// Directed self-checking bench for bg_subtract_detector (10x10 frames, 8-bit pixels, 4 training frames).
module tb_bg_subtract_detector;

    localparam int N = 100;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_mode = 1'b0;
    logic       i_valid = 1'b0;
    logic [7:0] i_data = 8'd0;
    logic [7:0] i_thresh = 8'd16;
    logic       i_ready = 1'b1;
    logic       o_in_ready, o_valid, o_fg, o_last, o_done_training;
    logic [7:0] o_data;
    logic [6:0] o_fg_count;

    bg_subtract_detector dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_mode          (i_mode),
        .i_valid         (i_valid),
        .i_data          (i_data),
        .o_in_ready      (o_in_ready),
        .i_thresh        (i_thresh),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_data          (o_data),
        .o_fg            (o_fg),
        .o_last          (o_last),
        .o_fg_count      (o_fg_count),
        .o_done_training (o_done_training)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    // Output capture: a beat transfers at the next posedge when o_valid && i_ready at negedge.
    int         out_total = 0;
    logic [7:0] out_data [2048];
    logic       out_fg   [2048];
    logic       out_last [2048];
    logic [6:0] out_cnt  [2048];

    always @(negedge i_clk) begin
        if (o_valid && i_ready && out_total < 2048) begin
            out_data[out_total] = o_data;
            out_fg[out_total]   = o_fg;
            out_last[out_total] = o_last;
            out_cnt[out_total]  = o_fg_count;
            out_total++;
        end
    end

    logic [7:0] frame_pix  [N];
    logic       frame_mode [N];

    task automatic fill(input logic [7:0] v, input logic m);
        for (int i = 0; i < N; i++) begin
            frame_pix[i]  = v;
            frame_mode[i] = m;
        end
    endtask

    task automatic send_pix(input logic [7:0] d, input logic m);
        int   guard;
        logic rdy;
        i_valid = 1'b1;
        i_data  = d;
        i_mode  = m;
        guard   = 0;
        do begin
            @(negedge i_clk);
            rdy = o_in_ready;
            @(posedge i_clk);
            #1;
            guard++;
        end while (!rdy && guard < 100);
        if (!rdy) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: o_in_ready stayed %b, required 1", rdy);
        end
        i_valid = 1'b0;
    endtask

    task automatic send_frame(input int upto);
        for (int i = 0; i < upto; i++) send_pix(frame_pix[i], frame_mode[i]);
    endtask

    task automatic drain();
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_valid = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
    endtask

    task automatic train_four(input logic [7:0] v);
        fill(v, 1'b0);
        for (int f = 0; f < 4; f++) begin
            send_frame(N - 1);
            n_vec++;
            if (o_done_training !== 1'b0) begin
                n_err++;
                $display("FAIL train_done_early frame %0d: got %b want 0", f, o_done_training);
            end
            send_pix(frame_pix[N-1], 1'b0);
            n_vec++;
            if (o_done_training !== (f == 3)) begin
                n_err++;
                $display("FAIL train_done frame %0d: got %b want %b", f, o_done_training, f == 3);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({o_valid, o_data, o_fg, o_last, o_fg_count, o_done_training, o_in_ready}
            !== {1'b0, 8'd0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_values: got v=%b d=%0d fg=%b l=%b c=%0d dt=%b r=%b want 0,0,0,0,0,0,1",
                     o_valid, o_data, o_fg, o_last, o_fg_count, o_done_training, o_in_ready);
        end
    endtask

    task automatic test_train_with_reset();
        int base;
        base = out_total;
        fill(8'd200, 1'b0);
        send_frame(N);
        send_frame(N);
        send_frame(40);
        do_reset();
        n_vec++;
        if (o_done_training !== 1'b0) begin
            n_err++;
            $display("FAIL done_after_reset: got %b want 0", o_done_training);
        end
        train_four(8'd100);
        drain();
        n_vec++;
        if (out_total !== base) begin
            n_err++;
            $display("FAIL train_no_output: got %0d beats want 0", out_total - base);
        end
    endtask

    task automatic test_detect();
        int base;
        logic [9:0] got, exp;
        fill(8'd100, 1'b1);
        frame_pix[37] = 8'd200;
        base = out_total;
        send_frame(N);
        drain();
        n_vec++;
        if (out_total - base !== N) begin
            n_err++;
            $display("FAIL detect_beats: got %0d want %0d", out_total - base, N);
        end
        for (int i = 0; i < N; i++) begin
            got = {out_data[base+i], out_fg[base+i], out_last[base+i]};
            exp = {frame_pix[i], i == 37, i == N - 1};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL detect_beat %0d: got %h want %h", i, got, exp);
            end
        end
        n_vec++;
        if (out_cnt[base+N-1] !== 7'd1 || o_fg_count !== 7'd1) begin
            n_err++;
            $display("FAIL detect_count: got %0d/%0d want 1", out_cnt[base+N-1], o_fg_count);
        end
    endtask

    task automatic test_threshold();
        int base;
        logic [9:0] got, exp;
        fill(8'd100, 1'b1);
        frame_pix[5] = 8'd116;
        frame_pix[6] = 8'd117;
        base = out_total;
        send_frame(N);
        drain();
        for (int i = 0; i < N; i++) begin
            got = {out_data[base+i], out_fg[base+i], out_last[base+i]};
            exp = {frame_pix[i], i == 6, i == N - 1};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL thresh_beat %0d: got %h want %h", i, got, exp);
            end
        end
        n_vec++;
        if (o_fg_count !== 7'd1) begin
            n_err++;
            $display("FAIL thresh_count: got %0d want 1", o_fg_count);
        end
    endtask

    task automatic test_backpressure();
        int base, k, g;
        logic [9:0] got, exp;
        fill(8'd100, 1'b1);
        for (int i = 0; i < N; i++) frame_pix[i] = 8'(100 + i % 8);
        base = out_total;
        fork
            send_frame(N);
            begin
                g = 0;
                while (out_total < base + 30 && g < 500) begin
                    @(posedge i_clk);
                    g++;
                end
                #1;
                i_ready = 1'b0;
                k = out_total - base;
                repeat (5) begin
                    @(negedge i_clk);
                    got = {o_data, o_fg, o_valid};
                    exp = {frame_pix[k], 1'b0, 1'b1};
                    n_vec++;
                    if (got !== exp || o_in_ready !== 1'b0) begin
                        n_err++;
                        $display("FAIL stall_hold beat %0d: got %h rdy=%b want %h rdy=0",
                                 k, got, o_in_ready, exp);
                    end
                end
                @(posedge i_clk);
                #1;
                i_ready = 1'b1;
            end
        join
        drain();
        n_vec++;
        if (out_total - base !== N) begin
            n_err++;
            $display("FAIL stall_beats: got %0d want %0d", out_total - base, N);
        end
        for (int i = 0; i < N; i++) begin
            got = {out_data[base+i], out_fg[base+i], out_last[base+i]};
            exp = {frame_pix[i], 1'b0, i == N - 1};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL stall_beat %0d: got %h want %h", i, got, exp);
            end
        end
        n_vec++;
        if (o_fg_count !== 7'd0) begin
            n_err++;
            $display("FAIL stall_count: got %0d want 0", o_fg_count);
        end
    endtask

    task automatic test_mode_toggle();
        int base;
        logic [9:0] got, exp;
        fill(8'd100, 1'b1);
        frame_pix[10] = 8'd200;
        for (int i = 50; i < N; i++) frame_mode[i] = 1'b0;
        base = out_total;
        send_frame(N);
        drain();
        n_vec++;
        if (out_total - base !== N) begin
            n_err++;
            $display("FAIL toggle_beats: got %0d want %0d", out_total - base, N);
        end
        for (int i = 0; i < N; i++) begin
            got = {out_data[base+i], out_fg[base+i], out_last[base+i]};
            exp = {frame_pix[i], i == 10, i == N - 1};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL toggle_beat %0d: got %h want %h", i, got, exp);
            end
        end
        fill(8'd100, 1'b0);
        base = out_total;
        send_frame(N);
        drain();
        n_vec++;
        if (out_total !== base || o_fg_count !== 7'd1 || o_done_training !== 1'b1) begin
            n_err++;
            $display("FAIL train_frame_in_detect: got beats=%0d cnt=%0d dt=%b want 0,1,1",
                     out_total - base, o_fg_count, o_done_training);
        end
    endtask

    task automatic test_adaptive();
        int base;
        logic [6:0] exp84;
        logic       fg84;
`ifdef ADAPTIVE_BG_EN
        fg84  = 1'b1;
        exp84 = 7'd100;
`else
        fg84  = 1'b0;
        exp84 = 7'd0;
`endif
        do_reset();
        train_four(8'd100);
        fill(8'd110, 1'b1);
        send_frame(N);
        drain();
        n_vec++;
        if (o_fg_count !== 7'd0) begin
            n_err++;
            $display("FAIL adapt_110_count: got %0d want 0", o_fg_count);
        end
        // 84 sits exactly on the threshold against bg 100 but beyond it against bg 102.
        fill(8'd84, 1'b1);
        base = out_total;
        send_frame(N);
        drain();
        for (int i = 0; i < N; i += 11) begin
            n_vec++;
            if (out_fg[base+i] !== fg84) begin
                n_err++;
                $display("FAIL adapt_84_fg beat %0d: got %b want %b", i, out_fg[base+i], fg84);
            end
        end
        n_vec++;
        if (o_fg_count !== exp84) begin
            n_err++;
            $display("FAIL adapt_84_count: got %0d want %0d", o_fg_count, exp84);
        end
        fill(8'd119, 1'b1);
        send_frame(N);
        drain();
        n_vec++;
        if (o_fg_count !== 7'd100) begin
            n_err++;
            $display("FAIL adapt_119_count: got %0d want 100", o_fg_count);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_train_with_reset();
        test_detect();
        test_threshold();
        test_backpressure();
        test_mode_toggle();
        test_adaptive();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
